alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_if.sv | 41 ++++
 rtl/alu_exec_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if -- request/response bundle for alu_exec_unit.
//
// Handshake rules (both channels follow them):
//   - A request transfers on a rising edge where in_valid && in_ready.
//     in_ready is high only while the unit is idle; in_valid seen at any
//     other time is ignored.
//   - A result transfers on a rising edge where out_valid && out_ready.
//     While out_valid is high, result/zero/illegal do not change.
//     out_ready has no effect while out_valid is low.
//
// Signals:
//   in_valid, alu_ctrl[3:0], a, b  : request (master -> unit)
//   in_ready                       : unit idle, can accept a request
//   out_valid, result, zero, illegal : response (unit -> master)
//   out_ready                      : consumer takes the result
//   busy                           : unit is not idle
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- multi-cycle ALU execute stage with valid/ready handshake.
//
// Ports:
//   clk        : single clock, all state on the rising edge
//   reset      : synchronous, active-high; aborts any in-flight operation
//   bus        : alu_exec_if.slave (request, response, busy)
//   dbg_state  : current FSM state encoding (IDLE=0, EXEC=1, DONE=2)
//
// Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed),
//        1000 LUI, 1100 NOR, 1001 MUL (only with ALU_EXEC_MUL_EN).
//        Any other code yields result 0 with illegal set.
//
// Configuration macro: ALU_EXEC_MUL_EN
//   defined   : MUL runs as a WIDTH-step shift-add through the EXEC state,
//               result valid WIDTH+1 cycles after acceptance.
//   undefined : no EXEC state, no multiplier; 1001 is an illegal code.
//
// Single-cycle ops go IDLE -> DONE at the accepting edge; the result is
// latched there, so later operand changes cannot disturb it.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu_exec_if.slave   bus,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
`ifdef ALU_EXEC_MUL_EN
    EXEC = 2'b01,
`endif
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam int         CW     = $clog2(WIDTH);

  // Shift-add multiplier: mcand shifts left, mplier shifts right, acc
  // accumulates mcand whenever the current multiplier LSB is set.
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;
`endif

  // Single-cycle operation result from the live request operands.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (bus.alu_ctrl)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_LUI:  alu_res = WIDTH'(bus.b[15:0]) << 16;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      default: begin
        alu_res   = '0;
        alu_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          result_d  = alu_res;
          illegal_d = !alu_legal;
          state_d   = DONE;
`ifdef ALU_EXEC_MUL_EN
          if (bus.alu_ctrl == OP_MUL) begin
            result_d  = result_q;
            illegal_d = illegal_q;
            mcand_d   = bus.a;
            mplier_d  = bus.b;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = EXEC;
          end
`endif
        end
      end
`ifdef ALU_EXEC_MUL_EN
      EXEC: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last step: publish the final sum directly so DONE lands exactly
        // WIDTH edges after the accepting edge.
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d  = acc_step;
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;
  // Zero flag derives from the latched result; gated so it reads 0 out of reset.
  assign bus.zero      = (state_q == DONE) && (result_q == '0);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LUI = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1001;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one request for one edge, then scramble the operands so a
  // design that re-reads them after acceptance gets caught.
  task automatic issue(input string tag, input logic [3:0] ctrl,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] exp_res);
    @(negedge clk);
    check({tag, "_ready"}, W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1;
    bus.alu_ctrl = ctrl;
    bus.a        = av;
    bus.b        = bv;
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.alu_ctrl = 4'($urandom_range(0, 15));
  endtask

  // Wait (bounded) for out_valid, check latency and payload, then consume.
  task automatic collect(input string tag, input int lat,
                         input logic exp_zero, input logic exp_ill);
    int           cycles;
    logic         hold_ok;
    logic [W-1:0] exp_res;
    hold_ok = 1'b1;
    @(negedge clk);
    cycles = 1;
    while (!bus.out_valid && cycles < 100) begin
      if (!bus.busy || bus.in_ready) hold_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    exp_res = exp_q.pop_front();
    check({tag, "_lat"},  W'(cycles), W'(lat));
    check({tag, "_busy"}, W'(hold_ok), W'(1));
    check({tag, "_res"},  bus.result, exp_res);
    check({tag, "_zero"}, W'(bus.zero), W'(exp_zero));
    check({tag, "_ill"},  W'(bus.illegal), W'(exp_ill));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, W'(bus.in_ready), W'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 4'h0;
    bus.a        = '0;
    bus.b        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_result",    bus.result, W'(0));
    check("rst_zero",      W'(bus.zero), W'(0));
    check("rst_illegal",   W'(bus.illegal), W'(0));
    check("rst_busy",      W'(bus.busy), W'(0));

    // Directed single-cycle vectors
    issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    collect("add_ovf", 1, 1'b0, 1'b0);
    issue("sub_eq", OP_SUB, 32'd5, 32'd5, 32'h0);
    collect("sub_eq", 1, 1'b1, 1'b0);
    issue("sub_neg", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
    collect("sub_neg", 1, 1'b0, 1'b0);
    issue("slt_t", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h1);
    collect("slt_t", 1, 1'b0, 1'b0);
    issue("slt_f", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'h0);
    collect("slt_f", 1, 1'b1, 1'b0);
    issue("lui", OP_LUI, 32'h1234_5678, 32'h0000_ABCD, 32'hABCD_0000);
    collect("lui", 1, 1'b0, 1'b0);
    issue("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF);
    collect("nor", 1, 1'b0, 1'b0);
    issue("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    collect("and", 1, 1'b0, 1'b0);
    issue("or", OP_OR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
    collect("or", 1, 1'b0, 1'b0);
    issue("ill3", 4'b0011, 32'h1111_1111, 32'h2222_2222, 32'h0);
    collect("ill3", 1, 1'b1, 1'b1);
    issue("illf", 4'b1111, 32'hDEAD_BEEF, 32'h1, 32'h0);
    collect("illf", 1, 1'b1, 1'b1);

`ifdef ALU_EXEC_MUL_EN
    issue("mul", OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
    collect("mul", W + 1, 1'b0, 1'b0);
    issue("mul2", OP_MUL, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD);
    collect("mul2", W + 1, 1'b0, 1'b0);
`else
    issue("mul", OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'h0);
    collect("mul", 1, 1'b1, 1'b1);
`endif

    // Back-pressure: result held, new requests ignored while DONE
    issue("hold", OP_ADD, 32'd2, 32'd3, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", W'(bus.out_valid), W'(1));
      check("hold_ready", W'(bus.in_ready), W'(0));
      check("hold_res",   bus.result, W'(5));
      bus.in_valid = 1'b1;
      bus.alu_ctrl = OP_SUB;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
    end
    @(negedge clk);
    check("hold_res_end", bus.result, exp_q.pop_front());
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("hold_idle",    W'(bus.in_ready), W'(1));
    check("hold_novalid", W'(bus.out_valid), W'(0));
    @(negedge clk);
    check("hold_stay_idle", W'(bus.busy), W'(0));

    // Reset aborts an in-flight operation
`ifdef ALU_EXEC_MUL_EN
    issue("rst_mul", OP_MUL, 32'h0000_1234, 32'h0000_0101, 32'h0);
    repeat (9) @(negedge clk);
    check("rst_mid_busy", W'(bus.busy), W'(1));
`else
    issue("rst_done", OP_ADD, 32'd9, 32'd9, 32'd18);
    @(negedge clk);
    check("rst_pre_res", bus.result, W'(18));
`endif
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready",  W'(bus.in_ready), W'(1));
    check("abort_valid",  W'(bus.out_valid), W'(0));
    check("abort_result", bus.result, W'(0));
    check("abort_busy",   W'(bus.busy), W'(0));
    check("abort_ill",    W'(bus.illegal), W'(0));
    issue("post_rst", OP_ADD, 32'd1, 32'd1, 32'd2);
    collect("post_rst", 1, 1'b0, 1'b0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
